// File: rtl/uart_block_pkg.sv
// Shared types and sizes for the UART block receiver.
package uart_block_pkg;

  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned BLOCK_BITS  = 512;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef enum logic {
    FILL,
    HOLD
  } asm_state_t;

endpackage

// File: rtl/uart_block_rx_uart_rx.sv
// 8N1 byte receiver: 2-FF synchronizer, start-bit qualification and centered sampling.
import uart_block_pkg::*;

module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       idle
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;

  logic             sync1, sync2;
  rx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic             valid_next, ferr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= rx;
      sync2      <= sync1;
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_idx_next;
      shift      <= shift_next;
      byte_valid <= valid_next;
      frame_err  <= ferr_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next     = '0;
        bit_idx_next = '0;
        if (!sync2) state_next = START;
      end
      START: begin
        if (cnt == CNT_W'(HALF)) begin
          cnt_next   = '0;
          // a line that has gone high again by mid-bit was only a glitch
          state_next = sync2 ? IDLE : DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_next   = '0;
          shift_next = {sync2, shift[7:1]};
          if (bit_idx == 3'd7) state_next = STOP;
          else bit_idx_next = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
          valid_next = sync2;
          ferr_next  = !sync2;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign byte_data = shift;
  assign idle      = (state == IDLE);

endmodule

// File: rtl/uart_block_rx.sv
// Packs 64 received UART bytes into a 512-bit block with valid/ready hand-off.
import uart_block_pkg::*;

module uart_block_rx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_uart_rx,
  output logic [BLOCK_BITS-1:0] block_data,
  output logic                  block_valid,
  input  logic                  block_ready,
  output logic [6:0]            byte_count,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  timeout
);

  localparam int unsigned GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned GAP_W     = $clog2(GAP_LIMIT + 1);

  logic                  byte_valid, rx_idle;
  logic [7:0]            byte_data;
  asm_state_t            asm_state, asm_next;
  logic [6:0]            count_next;
  logic [BLOCK_BITS-1:0] data_next;
  logic                  overrun_next, timeout_next;
  logic [GAP_W-1:0]      gap_cnt, gap_next;
  logic                  gap_active;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (i_uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .idle      (rx_idle)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_state  <= FILL;
      byte_count <= '0;
      block_data <= '0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      asm_state  <= asm_next;
      byte_count <= count_next;
      block_data <= data_next;
      overrun    <= overrun_next;
      timeout    <= timeout_next;
      gap_cnt    <= gap_next;
    end
  end

  assign gap_active = (asm_state == FILL) && (byte_count != '0) &&
                      (byte_count < 7'(BLOCK_BYTES));

  always_comb begin
    asm_next     = asm_state;
    count_next   = byte_count;
    data_next    = block_data;
    overrun_next = 1'b0;
    timeout_next = 1'b0;
    case (asm_state)
      FILL: begin
        if (frame_err) begin
          count_next = '0;
        end else if (byte_valid) begin
          data_next[{byte_count[5:0], 3'b000} +: 8] = byte_data;
          if (byte_count == 7'(BLOCK_BYTES - 1)) begin
            count_next = 7'(BLOCK_BYTES);
            asm_next   = HOLD;
          end else begin
            count_next = byte_count + 7'd1;
          end
        end else if (gap_active && rx_idle && gap_cnt == GAP_W'(GAP_LIMIT - 1)) begin
          count_next   = '0;
          timeout_next = 1'b1;
        end
      end
      HOLD: begin
        // handshake has priority; a coincident byte starts the next block
        if (block_ready) begin
          asm_next = FILL;
          if (byte_valid) begin
            data_next[7:0] = byte_data;
            count_next     = 7'd1;
          end else begin
            count_next = '0;
          end
        end else if (byte_valid) begin
          overrun_next = 1'b1;
        end
      end
      default: asm_next = FILL;
    endcase
  end

  // gap counter pauses while a byte is in flight and restarts on every byte
  always_comb begin
    gap_next = gap_cnt;
    if (!gap_active || byte_valid || timeout_next) gap_next = '0;
    else if (rx_idle) gap_next = gap_cnt + 1'b1;
  end

  assign block_valid = (asm_state == HOLD);

endmodule

// File: tb/tb_uart_block_rx.sv
// Directed bench for uart_block_rx with a byte scoreboard checked at each block hand-off.
module tb_uart_block_rx;

  localparam int unsigned CPB = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_line = 1'b1;
  logic         block_ready = 1'b0;
  logic [511:0] block_data;
  logic         block_valid;
  logic [6:0]   byte_count;
  logic         frame_err, overrun, timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int bv_cnt = 0, fe_cnt = 0, ov_cnt = 0, to_cnt = 0;
  logic [7:0] exp_q[$];
  logic prev_valid = 1'b0;
  logic prev_bv    = 1'b0;

  uart_block_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_uart_rx  (rx_line),
    .block_data (block_data),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .byte_count (byte_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = stop;
    repeat (CPB) @(negedge clk);
    rx_line = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    send_byte(b, 1'b1);
  endtask

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit && !block_valid; i++) @(negedge clk);
    check("valid_wait", block_valid, 1'b1);
  endtask

  // Monitor: pulse counters and block scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_bv    = 1'b0;
    end else begin
      if (dut.u_rx.byte_valid) bv_cnt++;
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (timeout)   to_cnt++;
      if (block_valid && !prev_valid) begin
        logic [511:0] exp_blk;
        exp_blk = '0;
        check("valid_latency", prev_bv, 1'b1);
        check("queue_depth", (exp_q.size() >= 64), 1'b1);
        for (int k = 0; k < 64 && exp_q.size() > 0; k++) exp_blk[k*8 +: 8] = exp_q.pop_front();
        check("block_content", block_data, exp_blk);
      end
      prev_valid = block_valid;
      prev_bv    = dut.u_rx.byte_valid;
    end
  end

  initial begin
    logic [511:0] snap;
    int base, seen;

    // reset state
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", block_valid, 1'b0);
    check("rst_count", byte_count, 7'd0);
    check("rst_data", block_data, '0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_timeout", timeout, 1'b0);

    // full block, back-to-back bytes 0x00..0x3F
    for (int i = 0; i < 64; i++) send_good(8'(i));
    wait_valid(40);
    check("full_byte0", block_data[7:0], 8'h00);
    check("full_byte63", block_data[511:504], 8'h3F);
    check("full_count", byte_count, 7'd64);
    repeat (20) @(negedge clk);
    check("full_held", block_valid, 1'b1);
    block_ready = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
    check("accept_valid", block_valid, 1'b0);
    check("accept_count", byte_count, 7'd0);

    // framing error discards the partial block
    for (int i = 0; i < 5; i++) send_good(8'(8'hA0 + i));
    check("pre_ferr_count", byte_count, 7'd5);
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_pulses", fe_cnt, 1);
    check("ferr_count", byte_count, 7'd0);
    exp_q.delete();
    for (int i = 0; i < 64; i++) send_good(8'($urandom_range(0, 255)));
    wait_valid(40);
    check("clean_count", byte_count, 7'd64);
    check("clean_no_ferr", fe_cnt, 1);

    // overrun while a block is held
    snap = block_data;
    base = ov_cnt;
    send_byte(8'hAA, 1'b1);
    repeat (4) @(negedge clk);
    check("overrun_pulses", ov_cnt, base + 1);
    check("overrun_data", block_data, snap);
    check("overrun_count", byte_count, 7'd64);
    check("overrun_valid", block_valid, 1'b1);

    // handshake coincident with an arriving byte
    exp_q.push_back(8'h68);
    seen = 0;
    fork
      send_byte(8'h68, 1'b1);
      begin
        for (int i = 0; i < 200 && seen == 0; i++) begin
          @(negedge clk);
          if (dut.u_rx.byte_valid) seen = 1;
        end
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
      end
    join
    check("simul_seen", seen, 1);
    check("simul_valid", block_valid, 1'b0);
    check("simul_count", byte_count, 7'd1);
    check("simul_byte0", block_data[7:0], 8'h68);
    base = to_cnt;
    for (int i = 0; i < 300 && to_cnt == base; i++) @(negedge clk);
    check("simul_timeout", to_cnt, base + 1);
    check("simul_to_count", byte_count, 7'd0);
    exp_q.delete();

    // idle gap of 160 cycles aborts, 150 cycles does not
    base = to_cnt;
    for (int i = 0; i < 3; i++) send_byte(8'(8'h10 + i), 1'b1);
    repeat (164) @(negedge clk);
    check("timeout_pulse", to_cnt, base + 1);
    check("timeout_count", byte_count, 7'd0);
    base = to_cnt;
    for (int i = 0; i < 3; i++) send_byte(8'(8'h20 + i), 1'b1);
    repeat (150) @(negedge clk);
    send_byte(8'h23, 1'b1);
    check("short_gap_pulse", to_cnt, base);
    check("short_gap_count", byte_count, 7'd4);

    // reset during bit 4 of byte 10, then a start-bit glitch
    for (int i = 0; i < 9; i++) send_byte(8'(8'h30 + i), 1'b1);
    fork
      send_byte(8'hF5, 1'b1);
      begin
        repeat (44) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    exp_q.delete();
    check("mid_rst_valid", block_valid, 1'b0);
    check("mid_rst_count", byte_count, 7'd0);
    check("mid_rst_data", block_data, '0);
    check("mid_rst_flags", {frame_err, overrun, timeout}, 3'b000);
    base = bv_cnt;
    rx_line = 1'b0;
    repeat (2) @(negedge clk);
    rx_line = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_bytes", bv_cnt, base);
    check("glitch_count", byte_count, 7'd0);
    send_byte(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    check("post_rst_bytes", bv_cnt, base + 1);
    check("post_rst_count", byte_count, 7'd1);
    check("post_rst_byte0", block_data[7:0], 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
